// File: rtl/rtc_pkg.sv
// Shared constants for the stopwatch timebase: default tick divider, counter
// width and the helper that sizes the prescaler register.
package rtc_pkg;

    localparam int DIV_DEFAULT   = 1000000;
    localparam int WIDTH_DEFAULT = 24;

    localparam logic [WIDTH_DEFAULT-1:0] CNT_MAX = '1;

    function automatic int presc_width(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides i_sclk down to a one-cycle tick every DIV enabled cycles. A paused
// prescaler keeps its partial count so the interval resumes where it stopped.
module rtc_prescaler
    import rtc_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic i_sclk,
    input  logic i_reset_n,
    input  logic clear,
    input  logic enb,
    output logic tick,
    output logic wrap
);

    localparam int              PW   = presc_width(DIV);
    localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("rtc_prescaler: DIV must be >= 2");
    end

    logic [PW-1:0] cnt_p0;

    // wrap is the combinational look-ahead of tick so a consumer can update
    // on the same edge that registers the tick pulse.
    assign wrap = enb & ~clear & (cnt_p0 == LAST);

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_p0 <= '0;
            tick   <= 1'b0;
        end else begin
            tick <= wrap;
            if (clear) begin
                cnt_p0 <= '0;
            end else if (enb) begin
                cnt_p0 <= wrap ? '0 : cnt_p0 + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtc_count_core.sv
// Stopwatch counting core: 10-ms timebase, saturating centisecond counter and
// a display latch that can freeze the shown value while counting continues.
module rtc_count_core
    import rtc_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             i_sclk,
    input  logic             i_reset_n,
    input  logic             i_count_init,
    input  logic             i_count_enb,
    input  logic             i_latch_count,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_disp_count,
    output logic             o_tick_10ms,
    output logic             o_running,
    output logic             o_overflow
);

    localparam logic [WIDTH-1:0] CNT_TOP = '1;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == CNT_TOP) ? v : v + 1'b1;
    endfunction

    function automatic logic hits_top(input logic [WIDTH-1:0] v);
        return (v == CNT_TOP);
    endfunction

    logic wrap;

    rtc_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .i_sclk    (i_sclk),
        .i_reset_n (i_reset_n),
        .clear     (i_count_init),
        .enb       (i_count_enb),
        .tick      (o_tick_10ms),
        .wrap      (wrap)
    );

    // Counter advances on the same edge the tick is registered, so tick and
    // the new count become visible together.
    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_count    <= '0;
            o_overflow <= 1'b0;
        end else if (i_count_init) begin
            o_count    <= '0;
            o_overflow <= 1'b0;
        end else if (wrap) begin
            o_count    <= sat_inc(o_count);
            o_overflow <= o_overflow | hits_top(o_count);
        end
    end

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_disp_count <= '0;
            o_running    <= 1'b0;
        end else begin
            o_running <= i_count_enb & ~i_count_init;
            if (i_count_init) begin
                o_disp_count <= '0;
            end else if (i_latch_count) begin
                o_disp_count <= o_count;
            end
        end
    end

endmodule

// File: tb/tb_rtc_count_core.sv
// Directed bench for rtc_count_core: a 24-bit and a 4-bit instance share the
// controls; a behavioural model queues expected outputs for every clock step.
module tb_rtc_count_core;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        count_init;
    logic        count_enb;
    logic        latch_count;

    logic [23:0] m_count, m_disp;
    logic        m_tick, m_run, m_ovf;
    logic [3:0]  s_count, s_disp;
    logic        s_tick, s_run, s_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pre;
        logic [23:0] cnt;
        logic [23:0] disp;
        logic        tick;
        logic        run;
        logic        ovf;
    } mst_t;

    typedef struct packed {
        mst_t m;
        mst_t s;
    } exp_t;

    mst_t mod_m;
    mst_t mod_s;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    rtc_count_core #(.DIV(DIV), .WIDTH(24)) dut (
        .i_sclk        (clk),
        .i_reset_n     (reset_n),
        .i_count_init  (count_init),
        .i_count_enb   (count_enb),
        .i_latch_count (latch_count),
        .o_count       (m_count),
        .o_disp_count  (m_disp),
        .o_tick_10ms   (m_tick),
        .o_running     (m_run),
        .o_overflow    (m_ovf)
    );

    rtc_count_core #(.DIV(DIV), .WIDTH(4)) dut_sat (
        .i_sclk        (clk),
        .i_reset_n     (reset_n),
        .i_count_init  (count_init),
        .i_count_enb   (count_enb),
        .i_latch_count (latch_count),
        .o_count       (s_count),
        .o_disp_count  (s_disp),
        .o_tick_10ms   (s_tick),
        .o_running     (s_run),
        .o_overflow    (s_ovf)
    );

    function automatic mst_t model(input mst_t s, input logic init, input logic enb,
                                   input logic latch, input logic [23:0] maxv);
        mst_t n;
        n      = s;
        n.tick = 1'b0;
        n.run  = enb & ~init;
        if (latch) n.disp = s.cnt;
        if (init) begin
            n.pre  = 0;
            n.cnt  = '0;
            n.disp = '0;
            n.ovf  = 1'b0;
        end else if (enb) begin
            if (s.pre == DIV - 1) begin
                n.pre  = 0;
                n.tick = 1'b1;
                if (s.cnt == maxv) n.ovf = 1'b1;
                else               n.cnt = s.cnt + 24'd1;
            end else begin
                n.pre = s.pre + 1;
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic init, input logic enb, input logic latch);
        exp_t e;
        count_init  = init;
        count_enb   = enb;
        latch_count = latch;
        mod_m = model(mod_m, init, enb, latch, 24'hFFFFFF);
        mod_s = model(mod_s, init, enb, latch, 24'h00000F);
        e.m = mod_m;
        e.s = mod_s;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("main.count",   32'(m_count), 32'(e.m.cnt));
        chk("main.disp",    32'(m_disp),  32'(e.m.disp));
        chk("main.tick",    32'(m_tick),  32'(e.m.tick));
        chk("main.running", 32'(m_run),   32'(e.m.run));
        chk("main.ovf",     32'(m_ovf),   32'(e.m.ovf));
        chk("sat.count",    32'(s_count), 32'(e.s.cnt));
        chk("sat.disp",     32'(s_disp),  32'(e.s.disp));
        chk("sat.tick",     32'(s_tick),  32'(e.s.tick));
        chk("sat.running",  32'(s_run),   32'(e.s.run));
        chk("sat.ovf",      32'(s_ovf),   32'(e.s.ovf));
    endtask

    task automatic run(input int n, input logic init, input logic enb, input logic latch);
        for (int i = 0; i < n; i++) step(init, enb, latch);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".count"},   32'(m_count), 32'd0);
        chk({tag, ".disp"},    32'(m_disp),  32'd0);
        chk({tag, ".tick"},    32'(m_tick),  32'd0);
        chk({tag, ".running"}, 32'(m_run),   32'd0);
        chk({tag, ".ovf"},     32'(m_ovf),   32'd0);
        chk({tag, ".s_count"}, 32'(s_count), 32'd0);
        chk({tag, ".s_ovf"},   32'(s_ovf),   32'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        count_init  = 1'b0;
        count_enb   = 1'b0;
        latch_count = 1'b0;
        mod_m       = '0;
        mod_s       = '0;
        #12;
        chk_all_zero("por");
        reset_n = 1'b1;

        // Run: 3 cycles of init, then 40 enabled+latched cycles
        run(3, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("run.running_rise", 32'(m_run), 32'd1);
        run(39, 1'b0, 1'b1, 1'b1);
        chk("run.count_after_40", 32'(m_count), 32'd10);
        chk("run.disp_lags", 32'(m_disp), 32'd9);
        step(1'b0, 1'b0, 1'b1);
        chk("run.disp_10", 32'(m_disp), 32'd10);

        // Lap freeze
        run(1, 1'b1, 1'b0, 1'b0);
        run(21, 1'b0, 1'b1, 1'b1);
        chk("lap.count5", 32'(m_count), 32'd5);
        chk("lap.disp5", 32'(m_disp), 32'd5);
        run(12, 1'b0, 1'b1, 1'b0);
        chk("lap.count8", 32'(m_count), 32'd8);
        chk("lap.disp_frozen", 32'(m_disp), 32'd5);
        step(1'b0, 1'b1, 1'b1);
        chk("lap.disp8", 32'(m_disp), 32'd8);

        // Pause mid-interval
        run(1, 1'b1, 1'b0, 1'b0);
        run(6, 1'b0, 1'b1, 1'b0);
        run(10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("pause.no_early_tick", 32'(m_tick), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("pause.resume_tick", 32'(m_tick), 32'd1);
        chk("pause.count2", 32'(m_count), 32'd2);

        // Simultaneous controls
        run(1, 1'b1, 1'b0, 1'b0);
        run(36, 1'b0, 1'b1, 1'b1);
        chk("simul.count9", 32'(m_count), 32'd9);
        step(1'b1, 1'b1, 1'b1);
        chk("simul.count0", 32'(m_count), 32'd0);
        chk("simul.disp0", 32'(m_disp), 32'd0);
        chk("simul.no_tick", 32'(m_tick), 32'd0);
        chk("simul.running0", 32'(m_run), 32'd0);

        // Saturation on the 4-bit instance
        run(60, 1'b0, 1'b1, 1'b1);
        chk("sat.count15", 32'(s_count), 32'd15);
        chk("sat.ovf_not_yet", 32'(s_ovf), 32'd0);
        run(4, 1'b0, 1'b1, 1'b1);
        chk("sat.ovf_16th", 32'(s_ovf), 32'd1);
        chk("sat.held15", 32'(s_count), 32'd15);
        chk("sat.main16", 32'(m_count), 32'd16);
        run(16, 1'b0, 1'b1, 1'b1);
        chk("sat.after20_count", 32'(s_count), 32'd15);
        chk("sat.after20_ovf", 32'(s_ovf), 32'd1);
        chk("sat.main20", 32'(m_count), 32'd20);
        step(1'b1, 1'b0, 1'b0);
        chk("sat.init_count", 32'(s_count), 32'd0);
        chk("sat.init_disp", 32'(s_disp), 32'd0);
        chk("sat.init_ovf", 32'(s_ovf), 32'd0);

        // Asynchronous reset mid-count
        run(28, 1'b0, 1'b1, 1'b1);
        chk("rst.count7", 32'(m_count), 32'd7);
        #3;
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst.async");
        mod_m = '0;
        mod_s = '0;
        count_init = 1'b1;
        #2;
        reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        chk_all_zero("rst.release");
        step(1'b1, 1'b1, 1'b1);
        chk_all_zero("rst.init_hold");
        run(5, 1'b0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_count_core.md
Name: rtc_count_core

Overview:
- Consumer end of the stopwatch trigger-control interface.
- Takes the count_init / count_enb / latch_count control triple and implements the 10-ms timebase plus the 24-bit centisecond counter.
- Also provides a display latch that freezes the shown value while the counter keeps running (lap/pause view).
- Sits between the trigger-detection FSM and the display/BCD formatting logic.

Parameters:
- DIV, 1000000, i_sclk cycles per 10-ms tick (1000000 at 100 MHz); must be >= 2.
- WIDTH, 24, width of the centisecond counter and the display value.

Ports:
- i_sclk  input  1  system clock
- i_reset_n  input  1  asynchronous, active-low reset
- i_count_init  input  1  level; clears prescaler, counter, display and overflow flag; overrides all other controls
- i_count_enb  input  1  level; prescaler and counter advance while 1
- i_latch_count  input  1  level; display follows the counter while 1, holds while 0
- o_count  output  WIDTH  live centisecond count
- o_disp_count  output  WIDTH  latched display value
- o_tick_10ms  output  1  one-cycle pulse per 10-ms interval elapsed
- o_running  output  1  registered (i_count_enb & ~i_count_init)
- o_overflow  output  1  sticky; counter reached 2^WIDTH-1 and saturated

Behaviour:
- Reset:
  - Clock domain is i_sclk; reset is i_reset_n, asynchronous, active-low.
  - While reset is asserted, every output and internal register is 0: prescaler, o_count, o_disp_count, o_tick_10ms, o_running, o_overflow.
  - Reset asserted mid-operation clears everything immediately; there is no restore.
- Priority each cycle: init > enb. Init wins even when enb and latch are also 1.
- Prescaler (range 0..DIV-1):
  - init=1: next value 0; tick=0.
  - init=0, enb=1: increments. When it equals DIV-1, it wraps to 0 and o_tick_10ms=1 on the next cycle (registered pulse, exactly 1 cycle wide).
  - init=0, enb=0: holds its value; no tick. A partial interval resumes where it stopped.
- Counter:
  - init=1: o_count <= 0 and o_overflow <= 0.
  - The same edge that registers o_tick_10ms=1 also registers o_count+1, so tick and the new count appear together.
  - First tick: with DIV=N, init released and enb=1 from cycle 0, tick and count=1 appear after edge N.
  - Saturation: if o_count == 2^WIDTH-1 at a tick, o_count holds and o_overflow <= 1. The flag stays set until init or reset; there is no wrap.
- Display:
  - init=1: o_disp_count <= 0.
  - init=0, latch=1: o_disp_count <= o_count (registered, one cycle behind o_count).
  - init=0, latch=0: hold.
  - Latch is independent of enb. enb=1/latch=0 freezes the display while counting continues. enb=0/latch=1 shows the stopped value.
- o_running <= enb & ~init, registered, with 1-cycle latency.
- Control inputs are synchronous to i_sclk (the upstream FSM registers them); no synchroniser in this block.

Decomposition:
- Shared package rtc_pkg:
  - default DIV constant and default WIDTH;
  - localparam CNT_MAX = 2^WIDTH-1;
  - the clog2-based prescaler width.
- One sub-module, rtc_prescaler (DIV parameter; inputs clear and enb; output tick). It is reused by any future timebase.
- The counter, display latch and flags stay in the top level.

Test Plan (DIV=4, WIDTH=24 unless noted):
- Reset: assert i_reset_n=0 mid-count with o_count=7 -> all outputs 0 in the same cycle. Release with init=1 -> outputs stay 0.
- Run: init=1 for 3 cycles, then enb=1, latch=1 for 40 cycles -> tick every 4th cycle, o_count=10 at the end, o_disp_count=10 one cycle later, o_running=1 one cycle after enb rises.
- Lap freeze: at o_count=5 drop latch for 12 cycles, enb still 1 -> o_disp_count stays 5 while o_count reaches 8. Raise latch -> o_disp_count=8 on the next cycle.
- Pause mid-interval: enb=1 for 2 cycles past a tick, enb=0 for 10 cycles, enb=1 -> next tick exactly 2 enabled cycles later; no tick while paused.
- Saturation (WIDTH=4): run 20 ticks -> o_count=15, o_overflow=1 from the 16th tick onward. Pulse init for 1 cycle -> o_count=0, o_disp_count=0, o_overflow=0.
- Simultaneous controls: init=1 with enb=1 and latch=1 while o_count=9 -> next cycle o_count=0, o_disp_count=0, no tick, o_running=0.
